// File: rtl/alu_issue_decoder.sv
// RV32 ALU issue decoder: decodes an instruction into an ALU control code plus operands
// and hands it downstream through a two-entry skid buffer.
module alu_issue_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_control,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic        illegal,
  output logic [15:0] issue_count
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic        illegal;
    logic [5:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic [4:0]  unused_rd;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_u     = {instr[31:12], 12'b0};
  assign shamt     = {27'b0, instr[24:20]};
  assign unused_rd = instr[11:7];

  logic        dec_ok;
  logic [5:0]  dec_ctrl;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  entry_t      dec;

  always_comb begin
    dec_ok   = 1'b0;
    dec_ctrl = 6'b111111;
    dec_op1  = 32'd0;
    dec_op2  = 32'd0;
    case (opcode)
      OPC_OP: begin
        dec_op1 = rs1_data;
        dec_op2 = rs2_data;
        case (funct7)
          7'b0000000: begin
            dec_ok = 1'b1;
            case (funct3)
              3'b000:  dec_ctrl = 6'b000010;
              3'b001:  dec_ctrl = 6'b000011;
              3'b100:  dec_ctrl = 6'b000101;
              3'b101:  dec_ctrl = 6'b000100;
              3'b110:  dec_ctrl = 6'b000001;
              3'b111:  dec_ctrl = 6'b000000;
              default: dec_ok   = 1'b0;
            endcase
          end
          7'b0100000: begin
            dec_ok = 1'b1;
            case (funct3)
              3'b000:  dec_ctrl = 6'b000110;
              3'b101:  dec_ctrl = 6'b000111;
              default: dec_ok   = 1'b0;
            endcase
          end
          7'b0000001: begin
            dec_ok   = 1'b1;
            dec_ctrl = {3'b010, funct3};
          end
          7'b0000101: begin
            dec_ok = 1'b1;
            case (funct3)
              3'b100:  dec_ctrl = 6'b100000;
              3'b101:  dec_ctrl = 6'b100010;
              3'b110:  dec_ctrl = 6'b100001;
              3'b111:  dec_ctrl = 6'b100011;
              default: dec_ok   = 1'b0;
            endcase
          end
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_op1 = rs1_data;
        dec_op2 = imm_i;
        dec_ok  = 1'b1;
        case (funct3)
          3'b000: dec_ctrl = 6'b000010;
          3'b100: dec_ctrl = 6'b000101;
          3'b110: dec_ctrl = 6'b000001;
          3'b111: dec_ctrl = 6'b000000;
          3'b001: begin
            dec_op2  = shamt;
            dec_ctrl = 6'b000011;
            dec_ok   = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec_op2 = shamt;
            if (funct7 == 7'b0000000)      dec_ctrl = 6'b000100;
            else if (funct7 == 7'b0100000) dec_ctrl = 6'b000111;
            else                           dec_ok   = 1'b0;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        dec_op1 = rs1_data;
        dec_op2 = rs2_data;
        dec_ok  = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl = 6'b001000;
          3'b001:  dec_ctrl = 6'b001001;
          3'b100:  dec_ctrl = 6'b001010;
          3'b101:  dec_ctrl = 6'b001011;
          3'b110:  dec_ctrl = 6'b001100;
          3'b111:  dec_ctrl = 6'b001101;
          default: dec_ok   = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_ok   = 1'b1;
        dec_ctrl = 6'b000010;
        dec_op2  = imm_u;
      end
      OPC_AUIPC: begin
        dec_ok   = 1'b1;
        dec_ctrl = 6'b000010;
        dec_op1  = pc;
        dec_op2  = imm_u;
      end
      default: dec_ok = 1'b0;
    endcase
    // Illegal words still flow downstream, but with a fixed code and zeroed operands
    if (!dec_ok) begin
      dec_ctrl = 6'b111111;
      dec_op1  = 32'd0;
      dec_op2  = 32'd0;
    end
  end

  assign dec = '{illegal: !dec_ok, ctrl: dec_ctrl, op1: dec_op1, op2: dec_op2};

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   in_xfer;
  logic   out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready    <= 1'b0;
      issue_count <= 16'd0;
    end else begin
      if (out_xfer) issue_count <= issue_count + 16'd1;
      // Main slot is free this edge: refill from skid first to preserve order
      if (!main_valid || out_ready) begin
        in_ready <= 1'b1;
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (in_xfer) begin
          main_q     <= dec;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end else begin
        in_ready <= !skid_valid;
      end
    end
  end

  assign out_valid   = main_valid;
  assign alu_control = main_q.ctrl;
  assign operand1    = main_q.op1;
  assign operand2    = main_q.op2;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed self-checking bench for alu_issue_decoder: decode codes, skid backpressure,
// mid-run reset and issue counter wrap.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_control;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        illegal;
  logic [15:0] issue_count;

  int passed = 0;
  int total  = 0;

  alu_issue_decoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .operand1(operand1), .operand2(operand2), .illegal(illegal),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd2, f3, 5'd1, 7'b0010011};
  endfunction

  function automatic logic [31:0] b_type(input logic [2:0] f3);
    return {7'd0, 5'd3, 5'd2, f3, 5'd0, 7'b1100011};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] word,
                               input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    instr    = word;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    pc = 32'd0;
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd9, 32'd9);
    tick();
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_count", issue_count, 0);
    checkOutput("rst_alu", alu_control, 0);
    checkOutput("rst_op1", operand1, 0);

    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);

    // ADD rs1=5 rs2=7
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd5, 32'd7);
    tick();
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_alu", alu_control, 6'b000010);
    checkOutput("add_op1", operand1, 5);
    checkOutput("add_op2", operand2, 7);
    checkOutput("add_illegal", illegal, 0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("add_count", issue_count, 1);
    checkOutput("add_drained", out_valid, 0);

    // Back-to-back decode stream at full throughput
    applyStimulus(1'b1, i_type(12'hFFF, 3'b000), 32'd3, 32'd0);
    tick();
    checkOutput("addi_alu", alu_control, 6'b000010);
    checkOutput("addi_op1", operand1, 3);
    checkOutput("addi_op2", operand2, 32'hFFFF_FFFF);
    applyStimulus(1'b1, i_type({7'b0100000, 5'd4}, 3'b101), 32'd3, 32'd0);
    tick();
    checkOutput("srai_alu", alu_control, 6'b000111);
    checkOutput("srai_op2", operand2, 4);
    pc = 32'h1000;
    applyStimulus(1'b1, {20'h12345, 5'd1, 7'b0010111}, 32'd77, 32'd0);
    tick();
    checkOutput("auipc_alu", alu_control, 6'b000010);
    checkOutput("auipc_op1", operand1, 32'h1000);
    checkOutput("auipc_op2", operand2, 32'h1234_5000);
    applyStimulus(1'b1, {25'd0, 7'b0000011}, 32'd11, 32'd12);
    tick();
    checkOutput("load_illegal", illegal, 1);
    checkOutput("load_alu", alu_control, 6'b111111);
    checkOutput("load_op1", operand1, 0);
    checkOutput("load_op2", operand2, 0);
    applyStimulus(1'b1, r_type(7'b0000101, 3'b101), 32'd20, 32'd21);
    tick();
    checkOutput("minu_alu", alu_control, 6'b100010);
    checkOutput("minu_illegal", illegal, 0);
    applyStimulus(1'b1, b_type(3'b111), 32'd30, 32'd31);
    tick();
    checkOutput("bgeu_alu", alu_control, 6'b001101);
    checkOutput("bgeu_op2", operand2, 31);
    applyStimulus(1'b1, r_type(7'b0000001, 3'b011), 32'd40, 32'd41);
    tick();
    checkOutput("mulhu_alu", alu_control, 6'b010011);
    applyStimulus(1'b1, {20'hABCDE, 5'd1, 7'b0110111}, 32'd50, 32'd51);
    tick();
    checkOutput("lui_op1", operand1, 0);
    checkOutput("lui_op2", operand2, 32'hABCD_E000);
    applyStimulus(1'b1, r_type(7'h00, 3'b010), 32'd60, 32'd61);
    tick();
    checkOutput("slt_illegal", illegal, 1);
    applyStimulus(1'b1, i_type({7'b0100000, 5'd2}, 3'b001), 32'd70, 32'd0);
    tick();
    checkOutput("slli_bad_illegal", illegal, 1);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("stream_count", issue_count, 11);
    checkOutput("stream_drained", out_valid, 0);

    // Backpressure: two entries buffered, third held upstream
    out_ready = 1'b0;
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd100, 32'd1);
    tick();
    checkOutput("bp_a_op1", operand1, 100);
    checkOutput("bp_a_ready", in_ready, 1);
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd200, 32'd1);
    tick();
    checkOutput("bp_hold_op1", operand1, 100);
    checkOutput("bp_full_ready", in_ready, 0);
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd300, 32'd1);
    tick();
    checkOutput("bp_hold2_op1", operand1, 100);
    checkOutput("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_b_op1", operand1, 200);
    checkOutput("bp_drain_ready", in_ready, 1);
    tick();
    checkOutput("bp_c_op1", operand1, 300);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("bp_count", issue_count, 14);
    checkOutput("bp_empty", out_valid, 0);

    // Reset with both entries occupied
    out_ready = 1'b0;
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd1, 32'd2);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_count", issue_count, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    checkOutput("mid_rst_after_valid", out_valid, 0);
    checkOutput("mid_rst_after_ready", in_ready, 1);

    // Counter wrap: 65536 transfers from zero
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd1, 32'd1);
    for (int i = 0; i < 65535; i++) tick();
    checkOutput("wrap_fffe", issue_count, 16'hFFFE);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("wrap_ffff", issue_count, 16'hFFFF);
    applyStimulus(1'b1, r_type(7'h00, 3'b000), 32'd1, 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("wrap_zero", issue_count, 16'h0000);
    checkOutput("wrap_empty", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
